// File: rtl/rr_mux_arb.sv
// N-channel arbitrating multiplexer with a one-entry registered output buffer.
// Supports round-robin, fixed-priority and forced-select arbitration modes.
module rr_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  // Handshake: a word moves on any rising edge where valid && ready on that
  // side. ready may depend on valid, never the reverse.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] osel_q, osel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] gidx, hi_idx, lo_idx, fp_idx;
  logic             gany, found_hi, found_lo, found_fp, found_sel;
  logic [N-1:0]     grant;
  logic             can_accept, xfer;

  assign can_accept = (state_q == EMPTY) || out_ready;

  // Grant selection: descending scans leave the lowest matching index last.
  always_comb begin
    hi_idx    = '0;
    lo_idx    = '0;
    fp_idx    = '0;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    found_fp  = 1'b0;
    found_sel = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fp_idx   = SEL_W'(i);
        found_fp = 1'b1;
        if (SEL_W'(i) >= ptr_q) begin
          hi_idx   = SEL_W'(i);
          found_hi = 1'b1;
        end else begin
          lo_idx   = SEL_W'(i);
          found_lo = 1'b1;
        end
        if (SEL_W'(i) == sel) found_sel = 1'b1;
      end
    end
    gidx = '0;
    gany = 1'b0;
    case (mode)
      2'd0: begin
        if (found_hi) begin
          gidx = hi_idx;
          gany = 1'b1;
        end else if (found_lo) begin
          gidx = lo_idx;
          gany = 1'b1;
        end
      end
      2'd2: begin
        gidx = sel;
        gany = found_sel;
      end
      default: begin
        gidx = fp_idx;
        gany = found_fp;
      end
    endcase
  end

  assign xfer = gany && can_accept && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      osel_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    osel_d  = osel_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = FULL;
      osel_d  = gidx;
      ptr_d   = (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;
      for (int i = 0; i < N; i++) begin
        if (SEL_W'(i) == gidx) data_d = in_data[i*WIDTH +: WIDTH];
      end
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output logic
  always_comb begin
    grant = '0;
    if (gany) grant = {{(N-1){1'b0}}, 1'b1} << gidx;
    in_ready  = rst ? '0 : (grant & {N{can_accept}});
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_sel   = osel_q;
  end

endmodule
